irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 131 +++++++++++++
 tb/tb_irq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source fixed-priority interrupt controller with MASK/PEND/STAT.
// Define IRQC_EDGE_EN for rising-edge request capture; default is level.
module irq_ctrl #(
    parameter int VEC_STEP = 2
) (
    input  logic        clock,
    input  logic        locked,
    input  logic [7:0]  src,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_din,
    output logic [7:0]  cfg_dout,
    input  logic        cpu_ie,
    output logic        irq,
    output logic [15:0] irq_vec,
    input  logic        ack,
    input  logic        reti
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] mask;
    logic [7:0] pend;
    logic [7:0] pend_n;
    logic [7:0] set_v;
    logic [7:0] clr_v;
    logic [7:0] req_v;
    logic [2:0] idx;
    logic [2:0] idx_n;
    logic [2:0] low;
    logic       ack_clr;
    logic       busy;
    logic [15:0] vec;

`ifdef IRQC_EDGE_EN
    logic [7:0] src_q;

    // Previous source levels for rising-edge detection
    always_ff @(posedge clock) begin
        if (!locked) src_q <= 8'h00;
        else         src_q <= src;
    end

    assign set_v = src & ~src_q;
`else
    assign set_v = src;
`endif

    assign req_v = pend & mask;

    // Lowest set bit wins: bit 0 has the highest priority
    always_comb begin
        low = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_v[i]) low = 3'(i);
        end
    end

    // Next-state logic; idx is captured only when leaving IDLE
    always_comb begin
        state_n = state;
        idx_n   = idx;
        ack_clr = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_ie && (req_v != 8'h00)) begin
                    state_n = REQ;
                    idx_n   = low;
                end
            end
            REQ: begin
                if (ack) begin
                    state_n = SERVICE;
                    ack_clr = 1'b1;
                end else if (!(pend[idx] && mask[idx]) || !cpu_ie) begin
                    state_n = IDLE;
                end
            end
            SERVICE: begin
                if (reti) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // W1C from the bus and ack clear; a new request in the same cycle wins
    always_comb begin
        clr_v = 8'h00;
        if (cfg_we && (cfg_addr == 2'd1)) clr_v = cfg_din;
        if (ack_clr) clr_v = clr_v | (8'h01 << idx);
        pend_n = (pend & ~clr_v) | set_v;
    end

    // State, priority index and register file
    always_ff @(posedge clock) begin
        if (!locked) begin
            state <= IDLE;
            idx   <= 3'd0;
            pend  <= 8'h00;
            mask  <= 8'h00;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            pend  <= pend_n;
            if (cfg_we && (cfg_addr == 2'd0)) mask <= cfg_din;
        end
    end

    assign busy    = (state != IDLE);
    assign irq     = (state == REQ);
    assign vec     = 16'(VEC_STEP) * (16'(idx) + 16'd1);
    assign irq_vec = busy ? vec : 16'h0000;

    // Register read mux
    always_comb begin
        cfg_dout = 8'h00;
        unique case (1'b1)
            (cfg_addr == 2'd0): cfg_dout = mask;
            (cfg_addr == 2'd1): cfg_dout = pend;
            (cfg_addr == 2'd2): cfg_dout = {busy, 4'b0000, idx};
            default:            cfg_dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table vectors, directed corner sequences and random traffic
// checked against a behavioural model of the interrupt controller.
module tb_irq_ctrl;

    localparam int VS = 2;

`ifdef IRQC_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        locked = 1'b0;
    logic [7:0]  src = 8'h00;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [7:0]  cfg_din = 8'h00;
    logic [7:0]  cfg_dout;
    logic        cpu_ie = 1'b0;
    logic        irq;
    logic [15:0] irq_vec;
    logic        ack = 1'b0;
    logic        reti = 1'b0;

    always #5 clock = ~clock;

    irq_ctrl #(.VEC_STEP(VS)) dut (
        .clock    (clock),
        .locked   (locked),
        .src      (src),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_din  (cfg_din),
        .cfg_dout (cfg_dout),
        .cpu_ie   (cpu_ie),
        .irq      (irq),
        .irq_vec  (irq_vec),
        .ack      (ack),
        .reti     (reti)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model: active = index being handled, -1 when none
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_mask = 8'h00;
    logic [7:0] m_prev = 8'h00;
    int         m_active = -1;
    bit         m_serving = 1'b0;
    int         m_last = 0;

    function automatic int lowest(logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_update();
        logic [7:0] nreq;
        logic [7:0] clr;
        nreq = EDGE ? (src & ~m_prev) : src;
        if (!locked) begin
            m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
            m_active = -1; m_serving = 1'b0; m_last = 0;
            return;
        end
        clr = (cfg_we && cfg_addr == 2'd1) ? cfg_din : 8'h00;
        if (m_active < 0) begin
            if (cpu_ie && (m_pend & m_mask) != 8'h00) begin
                m_active = lowest(m_pend & m_mask);
                m_serving = 1'b0;
                m_last = m_active;
            end
        end else if (!m_serving) begin
            if (ack) begin
                clr[m_active] = 1'b1;
                m_serving = 1'b1;
            end else if (!m_pend[m_active] || !m_mask[m_active] || !cpu_ie) begin
                m_active = -1;
            end
        end else if (reti) begin
            m_active = -1;
            m_serving = 1'b0;
        end
        m_pend = (m_pend & ~clr) | nreq;
        if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_din;
        m_prev = src;
    endtask

    function automatic logic exp_irq();
        return (m_active >= 0) && !m_serving;
    endfunction

    function automatic logic [15:0] exp_vec();
        return (m_active >= 0) ? 16'(VS * (m_active + 1)) : 16'h0000;
    endfunction

    function automatic logic [7:0] exp_dout();
        case (cfg_addr)
            2'd0: return m_mask;
            2'd1: return m_pend;
            2'd2: return {(m_active >= 0), 4'b0000, 3'(m_last)};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check("model_irq", {15'b0, irq}, {15'b0, exp_irq()});
        check("model_vec", irq_vec, exp_vec());
        check("model_dout", {8'b0, cfg_dout}, {8'b0, exp_dout()});
    endtask

    task automatic clr_in();
        src = 8'h00; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_din = 8'h00; ack = 1'b0; reti = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        locked = 1'b0;
        step();
        locked = 1'b1;
    endtask

    typedef struct {
        logic        locked;
        logic [7:0]  src;
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  din;
        logic        ie;
        logic        ack;
        logic        reti;
        logic        x_irq;
        logic [15:0] x_vec;
        logic [7:0]  x_dout;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // src[2] pulse through request, ack, service and reti
        tbl[0] = '{1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[1] = '{1'b1, 8'h00, 1'b1, 2'd0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h04};
        tbl[2] = '{1'b1, 8'h04, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h04};
        tbl[3] = '{1'b1, 8'h00, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0006, 8'h04};
        tbl[4] = '{1'b1, 8'h00, 1'b0, 2'd2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0006, 8'h82};
        tbl[5] = '{1'b1, 8'h00, 1'b0, 2'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 8'h00};
        tbl[6] = '{1'b1, 8'h00, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h02};
        tbl[7] = '{1'b1, 8'h00, 1'b0, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};

        for (int i = 0; i < 8; i++) begin
            locked = tbl[i].locked; src = tbl[i].src;
            cfg_we = tbl[i].we; cfg_addr = tbl[i].addr;
            cfg_din = tbl[i].din; cpu_ie = tbl[i].ie;
            ack = tbl[i].ack; reti = tbl[i].reti;
            step();
            check($sformatf("tbl%0d_irq", i), {15'b0, irq}, {15'b0, tbl[i].x_irq});
            check($sformatf("tbl%0d_vec", i), irq_vec, tbl[i].x_vec);
            check($sformatf("tbl%0d_dout", i), {8'b0, cfg_dout}, {8'b0, tbl[i].x_dout});
        end

        // Two simultaneous sources: priority order, then re-request
        do_reset();
        cpu_ie = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_din = 8'hFF;
        step();
        clr_in(); src = 8'h22;
        step();
        check("prio_idle_irq", {15'b0, irq}, 16'h0000);
        src = 8'h00;
        step();
        check("prio_first_irq", {15'b0, irq}, 16'h0001);
        check("prio_first_vec", irq_vec, 16'h0004);
        ack = 1'b1;
        step();
        check("prio_ack_irq", {15'b0, irq}, 16'h0000);
        ack = 1'b0; reti = 1'b1;
        step();
        check("prio_reti_irq", {15'b0, irq}, 16'h0000);
        reti = 1'b0;
        step();
        check("prio_second_irq", {15'b0, irq}, 16'h0001);
        check("prio_second_vec", irq_vec, 16'h000C);

        // cpu_ie drop while requesting abandons the request, PEND kept
        do_reset();
        cpu_ie = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_din = 8'h08;
        step();
        clr_in(); src = 8'h08;
        step();
        src = 8'h00;
        step();
        check("ie_req_irq", {15'b0, irq}, 16'h0001);
        check("ie_req_vec", irq_vec, 16'h0008);
        cpu_ie = 1'b0; cfg_addr = 2'd1;
        step();
        check("ie_drop_irq", {15'b0, irq}, 16'h0000);
        check("ie_drop_vec", irq_vec, 16'h0000);
        check("ie_drop_pend", {8'b0, cfg_dout}, 16'h0008);
        cfg_addr = 2'd2;
        step();
        check("ie_drop_stat", {8'b0, cfg_dout}, 16'h0003);

        // Reset while in service, with a write that must be ignored
        do_reset();
        cpu_ie = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_din = 8'h10;
        step();
        clr_in(); src = 8'h10;
        step();
        src = 8'h00;
        step();
        ack = 1'b1; cfg_addr = 2'd2;
        step();
        check("rst_svc_stat", {8'b0, cfg_dout}, 16'h0084);
        ack = 1'b0; locked = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_din = 8'hFF;
        step();
        check("rst_mask", {8'b0, cfg_dout}, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        locked = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd1;
        step();
        check("rst_pend", {8'b0, cfg_dout}, 16'h0000);
        reti = 1'b1; cfg_addr = 2'd2;
        step();
        check("rst_reti_stat", {8'b0, cfg_dout}, 16'h0000);
        reti = 1'b0;
        step();
        check("rst_reti_irq", {15'b0, irq}, 16'h0000);

        // W1C colliding with a new request on the same bit
        do_reset();
        cpu_ie = 1'b0;
        step();
        src = 8'h01; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_din = 8'h01;
        step();
        check("w1c_set_wins", {8'b0, cfg_dout}, 16'h0001);
        step();
        check("w1c_held_src", {8'b0, cfg_dout}, EDGE ? 16'h0000 : 16'h0001);
        clr_in();
        step();

`ifndef IRQC_EDGE_EN
        // Level source held high re-requests after service
        do_reset();
        cpu_ie = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_din = 8'h80;
        step();
        clr_in(); src = 8'h80;
        step();
        step();
        check("lvl_req_irq", {15'b0, irq}, 16'h0001);
        check("lvl_req_vec", irq_vec, 16'h0010);
        ack = 1'b1; cfg_addr = 2'd1;
        step();
        check("lvl_ack_irq", {15'b0, irq}, 16'h0000);
        check("lvl_ack_pend", {8'b0, cfg_dout}, 16'h0080);
        ack = 1'b0; reti = 1'b1;
        step();
        check("lvl_reti_irq", {15'b0, irq}, 16'h0000);
        reti = 1'b0;
        step();
        check("lvl_rereq_irq", {15'b0, irq}, 16'h0001);
        check("lvl_rereq_vec", irq_vec, 16'h0010);
`endif

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            locked   = ($urandom_range(0, 63) != 0);
            src      = 8'($urandom & $urandom);
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_din  = 8'($urandom);
            cpu_ie   = ($urandom_range(0, 7) != 0);
            ack      = ($urandom_range(0, 3) == 0);
            reti     = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
